instruction_fetch_stage: RTL

Front-end stage of the pipelined RISC-V CPU: owns the PC, issues one-at-a-time requests to a variable-latency instruction memory, and drives the IF/ID pipeline register consumed by decode and the hazard-detection logic. It honours the stall/flush controls from hazard detection and redirects the PC on a taken branch or jump resolved in EX/MEM. Wrong-path responses still in flight are dropped without being delivered.

---
 rtl/instruction_fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a time to a
// variable-latency instruction memory and drives the IF/ID pipeline register.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        IF_ID_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_instr
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   hold_q;

  logic              deliver_c;
  logic              load_c;
  logic [XLEN-1:0]   fetch_data_c;
  logic [XLEN-1:0]   pc_plus4_c;
  logic [XLEN-1:0]   redirect_tgt_c;

  // Request strobe is combinational so a same-cycle redirect suppresses the stale fetch.
  assign imem_req       = (state_q == S_REQ) && !redirect_valid && !rst;
  assign imem_addr      = pc_q;
  assign deliver_c      = !Stall && !IF_ID_flush && !redirect_valid;
  assign load_c         = deliver_c && (((state_q == S_WAIT) && imem_rvalid) || (state_q == S_HOLD));
  assign fetch_data_c   = (state_q == S_HOLD) ? hold_q : imem_rdata;
  assign pc_plus4_c     = pc_q + XLEN'(4);
  assign redirect_tgt_c = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      hold_q      <= '0;
      IF_ID_valid <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_pc4   <= '0;
      IF_ID_instr <= NOP_INSTR;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (redirect_valid) pc_q <= redirect_tgt_c;
          else                state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect_valid) begin
              pc_q    <= redirect_tgt_c;
              state_q <= S_REQ;
            end else if (deliver_c) begin
              pc_q    <= pc_plus4_c;
              state_q <= S_REQ;
            end else begin
              hold_q  <= imem_rdata;
              state_q <= S_HOLD;
            end
          end else if (redirect_valid) begin
            pc_q    <= redirect_tgt_c;
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_tgt_c;
            state_q <= S_REQ;
          end else if (deliver_c) begin
            pc_q    <= pc_plus4_c;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          // Wrong-path response is swallowed; a newer redirect still updates the PC.
          if (redirect_valid) pc_q <= redirect_tgt_c;
          if (imem_rvalid)    state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      if (IF_ID_flush || redirect_valid) begin
        IF_ID_valid <= 1'b0;
        IF_ID_instr <= NOP_INSTR;
      end else if (!Stall) begin
        if (load_c) begin
          IF_ID_valid <= 1'b1;
          IF_ID_pc    <= pc_q;
          IF_ID_pc4   <= pc_plus4_c;
          IF_ID_instr <= fetch_data_c;
        end else begin
          IF_ID_valid <= 1'b0;
          IF_ID_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule
